// File: rtl/truth_sweeper.sv
// truth_sweeper: walks WXYZ through 0..15, samples F and scores it against EXPECTED_MASK.
// Optional abort input enabled by defining TRUTH_SWEEPER_ABORT_EN.
module truth_sweeper #(
  parameter logic [15:0] EXPECTED_MASK = 16'hDF03,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
`ifdef TRUTH_SWEEPER_ABORT_EN
  input  logic        abort,
`endif
  output logic [3:0]  wxyz_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail,
  output logic        first_fail_valid,
  output logic        pass
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [3:0]  r_wxyz;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_truth;
  logic [4:0]  r_mis;
  logic [3:0]  r_ff;
  logic        r_ffv;
  logic        r_pass;

  state_t      w_state_nxt;
  logic [3:0]  w_idx_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  w_wxyz_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic [15:0] w_truth_nxt;
  logic [4:0]  w_mis_nxt;
  logic [3:0]  w_ff_nxt;
  logic        w_ffv_nxt;
  logic        w_pass_nxt;

  logic        w_abort;
  logic        w_do_abort;
  logic        w_miss;
  logic [4:0]  w_mis_inc;
  logic [3:0]  w_idx_inc;
  state_t      w_vec_entry;

`ifdef TRUTH_SWEEPER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_do_abort  = w_abort &&
                       (r_state == ST_SETTLE || r_state == ST_SAMPLE);
  assign w_miss      = f_in ^ EXPECTED_MASK[r_idx];
  assign w_mis_inc   = r_mis + 5'd1;
  assign w_idx_inc   = r_idx + 4'd1;
  assign w_vec_entry = NO_SETTLE ? ST_SAMPLE : ST_SETTLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
      r_cnt   <= 4'd0;
      r_wxyz  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_truth <= 16'd0;
      r_mis   <= 5'd0;
      r_ff    <= 4'd0;
      r_ffv   <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wxyz  <= w_wxyz_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_truth <= w_truth_nxt;
      r_mis   <= w_mis_nxt;
      r_ff    <= w_ff_nxt;
      r_ffv   <= w_ffv_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_wxyz_nxt  = r_wxyz;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_truth_nxt = r_truth;
    w_mis_nxt   = r_mis;
    w_ff_nxt    = r_ff;
    w_ffv_nxt   = r_ffv;
    w_pass_nxt  = r_pass;

    if (w_do_abort) begin
      // partial results stay visible; only status is dropped
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = 4'd0;
      w_cnt_nxt   = 4'd0;
      w_wxyz_nxt  = 4'd0;
      w_busy_nxt  = 1'b0;
      w_pass_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_busy_nxt = 1'b0;
          w_wxyz_nxt = 4'd0;
          if (start) begin
            w_truth_nxt = 16'd0;
            w_mis_nxt   = 5'd0;
            w_ff_nxt    = 4'd0;
            w_ffv_nxt   = 1'b0;
            w_pass_nxt  = 1'b0;
            w_idx_nxt   = 4'd0;
            w_cnt_nxt   = SETTLE_LD;
            w_busy_nxt  = 1'b1;
            w_state_nxt = w_vec_entry;
          end
        end
        ST_SETTLE: begin
          if (r_cnt <= 4'd1) begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_SAMPLE;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
        ST_SAMPLE: begin
          w_truth_nxt[r_idx] = f_in;
          if (w_miss) begin
            w_mis_nxt = w_mis_inc;
            if (!r_ffv) begin
              w_ff_nxt  = r_idx;
              w_ffv_nxt = 1'b1;
            end
          end
          if (r_idx == 4'd15) begin
            w_state_nxt = ST_DONE;
            w_idx_nxt   = 4'd0;
            w_wxyz_nxt  = 4'd0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = w_miss ? 1'b0 : (r_mis == 5'd0);
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_wxyz_nxt  = w_idx_inc;
            w_cnt_nxt   = SETTLE_LD;
            w_state_nxt = w_vec_entry;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign wxyz_out         = r_wxyz;
  assign busy             = r_busy;
  assign done             = r_done;
  assign truth            = r_truth;
  assign mismatch_cnt     = r_mis;
  assign first_fail       = r_ff;
  assign first_fail_valid = r_ffv;
  assign pass             = r_pass;

endmodule
